// File: rtl/ram_load_sequencer.sv
// SRAM preload sequencer: decodes LOAD/RUN/HALT from the SPI byte stream, packs payload into
// 32-bit RAM writes and owns the core reset. Optional trailing checksum byte: RAM_LOAD_CHECKSUM_EN.
module ram_load_sequencer #(
  parameter logic [31:0] BaseAddr   = 32'h0010_0000,
  parameter int unsigned RamWords   = 16384,
  parameter int unsigned RspTimeout = 255
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  input  logic        a_rvalid_i,
  output logic        req_o,
  output logic        en_o,
  output logic [3:0]  b_en_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        rst_no,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [32:0] RamEnd = 33'(BaseAddr) + 33'(RamWords) * 33'd4;
  localparam int unsigned TmoW = (RspTimeout > 1) ? $clog2(RspTimeout) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RspTimeout - 1);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_LEN, S_DATA, S_WRITE, S_WAIT_RSP, S_DRAIN
`ifdef RAM_LOAD_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            live_q;
  logic [1:0]      byte_cnt;
  logic [7:0]      len_lo;
  logic [15:0]     len_full;
  logic [15:0]     words_left;
  logic [17:0]     drain_left;
  logic [TmoW-1:0] tmo_q;
  logic [32:0]     addr_next;
  logic            addr_ok;
  logic            rx_fire;
  logic            run_ok;
  logic            err_set, err_clr, run_set, run_clr;
  logic            drain_load;
  logic [15:0]     drain_words;

`ifdef RAM_LOAD_CHECKSUM_EN
  localparam state_t BlkDone = S_CSUM;
  logic [7:0] csum_q;
  assign run_ok = ~err_o;
`else
  localparam state_t BlkDone = S_CMD;
  assign run_ok = 1'b1;
`endif

  assign rx_fire   = rx_valid_i && rx_ready_o;
  assign addr_next = {1'b0, addr_o} + 33'd4;
  assign addr_ok   = (addr_o[1:0] == 2'b00) && (addr_o >= BaseAddr) && ({1'b0, addr_o} < RamEnd);
  assign req_o     = (state_q == S_WRITE);
  assign en_o      = req_o;
  assign b_en_o    = (state_q == S_WRITE || state_q == S_WAIT_RSP) ? 4'hF : '0;
  assign busy_o    = (state_q != S_CMD);

  // live_q keeps rx_ready_o low until the first edge after reset release
  always_comb begin
    case (state_q)
      S_CMD, S_ADDR, S_LEN, S_DATA, S_DRAIN: rx_ready_o = live_q;
`ifdef RAM_LOAD_CHECKSUM_EN
      S_CSUM:                                rx_ready_o = live_q;
`endif
      default:                               rx_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) state_q <= S_CMD;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    run_set     = 1'b0;
    run_clr     = 1'b0;
    drain_load  = 1'b0;
    drain_words = '0;
    len_full    = {rx_data_i, len_lo};
    case (state_q)
      S_CMD: if (rx_fire) begin
        case (rx_data_i)
          8'h01: begin err_clr = 1'b1; run_clr = 1'b1; state_d = S_ADDR; end
          8'h02: run_set = run_ok;
          8'h03: run_clr = 1'b1;
          default: err_set = 1'b1;
        endcase
      end
      S_ADDR: if (rx_fire && byte_cnt == 2'd3) state_d = S_LEN;
      S_LEN: if (rx_fire && byte_cnt[0]) begin
        err_set = ~addr_ok;
        if (len_full == '0) begin
          state_d = BlkDone;
        end else if (!addr_ok) begin
          state_d     = S_DRAIN;
          drain_load  = 1'b1;
          drain_words = len_full;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_fire && byte_cnt == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = S_WAIT_RSP;
      // completion and timeout share the block-exit path; only overrun needs a valid response
      S_WAIT_RSP: if (a_rvalid_i || tmo_q == TmoLast) begin
        if (words_left == 16'd1) begin
          state_d = BlkDone;
          err_set = ~a_rvalid_i;
        end else if (!a_rvalid_i || addr_next >= RamEnd) begin
          state_d     = S_DRAIN;
          err_set     = 1'b1;
          drain_load  = 1'b1;
          drain_words = words_left - 16'd1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DRAIN: if (rx_fire && drain_left == 18'd1) state_d = BlkDone;
`ifdef RAM_LOAD_CHECKSUM_EN
      S_CSUM: if (rx_fire) begin
        err_set = (rx_data_i != csum_q);
        state_d = S_CMD;
      end
`endif
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      live_q     <= 1'b0;
      err_o      <= 1'b0;
      rst_no     <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      byte_cnt   <= '0;
      len_lo     <= '0;
      words_left <= '0;
      drain_left <= '0;
      tmo_q      <= '0;
    end else begin
      live_q <= 1'b1;
      if (err_set)      err_o <= 1'b1;
      else if (err_clr) err_o <= 1'b0;
      if (run_set)      rst_no <= 1'b1;
      else if (run_clr) rst_no <= 1'b0;
      case (state_q)
        S_CMD: byte_cnt <= '0;
        S_ADDR: if (rx_fire) begin
          addr_o[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_LEN: if (rx_fire) begin
          if (byte_cnt[0]) begin
            words_left <= len_full;
            byte_cnt   <= '0;
          end else begin
            len_lo   <= rx_data_i;
            byte_cnt <= 2'd1;
          end
        end
        S_DATA: if (rx_fire) begin
          data_o[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_WRITE: tmo_q <= '0;
        S_WAIT_RSP: begin
          if (!a_rvalid_i) tmo_q <= tmo_q + TmoW'(1);
          if (state_d != S_WAIT_RSP) words_left <= words_left - 16'd1;
          if (state_d == S_DATA) addr_o <= addr_next[31:0];
        end
        S_DRAIN: if (rx_fire) drain_left <= drain_left - 18'd1;
        default: ;
      endcase
      if (drain_load) drain_left <= {drain_words, 2'b00};
    end
  end

`ifdef RAM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      csum_q <= '0;
    end else if (rx_fire) begin
      case (state_q)
        S_CMD:                           csum_q <= '0;
        S_ADDR, S_LEN, S_DATA, S_DRAIN:  csum_q <= csum_q + rx_data_i;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: doc/ram_load_sequencer.md
# ram_load_sequencer

Sequences SRAM preload on the FPGA top level. It consumes a byte stream from the SPI slave, already synchronised into `clk_sys`, and decodes LOAD/RUN/HALT commands. It packs payload bytes into 32-bit words and issues one write at a time on the demo system's external RAM port, waiting for each completion. It also owns the core reset, holding the Ibex core in reset until the image is loaded and a RUN command is received.

## Interface
- `BaseAddr`, 32'h0010_0000, byte address of RAM word 0.
- `RamWords`, 16384, RAM size in 32-bit words.
- `RspTimeout`, 255, maximum cycles to wait for `a_rvalid_i` after a write.

- `clk_sys` in 1: system clock; the only clock.
- `rst_sys_n` in 1: reset, asynchronous, active-low.
- `rx_valid_i` in 1: SPI byte valid.
- `rx_data_i` in 8: SPI byte.
- `rx_ready_o` out 1: byte accepted when `rx_valid_i && rx_ready_o`.
- `a_rvalid_i` in 1: RAM write completion.
- `req_o` out 1: RAM request strobe.
- `en_o` out 1: RAM write enable.
- `b_en_o` out 4: byte enables.
- `addr_o` out 32: RAM byte address.
- `data_o` out 32: RAM write data.
- `rst_no` out 1: core reset, active-low.
- `busy_o` out 1: high in any state other than CMD.
- `err_o` out 1: sticky error flag.

## Operation
- Reset values: `rx_ready_o`=0, `req_o`=0, `en_o`=0, `b_en_o`=0, `addr_o`=0, `data_o`=0, `rst_no`=0, `busy_o`=0, `err_o`=0.
- The state is CMD on the first edge after reset deassertion.
- States: CMD, ADDR (4 bytes), LEN (2 bytes), DATA (4 bytes), WRITE, WAIT_RSP, DRAIN, CSUM (macro only).
- Multi-byte fields are little-endian.
- CMD decodes each opcode byte:
  - 0x01 LOAD: clears `err_o`, drives `rst_no`=0, goes to ADDR.
  - 0x02 RUN: sets `rst_no`=1 and stays in CMD.
  - 0x03 HALT: sets `rst_no`=0 and stays in CMD.
  - Any other byte: sets `err_o` and stays in CMD.
- ADDR→LEN: LEN carries a 16-bit word count N.
  - N=0: go straight to CMD (or to CSUM when the macro is defined).
  - Otherwise go to DATA.
- Address check, applied once LEN completes: an address with `addr[1:0]`≠0, below `BaseAddr`, or with `BaseAddr+4*RamWords` ≤ addr is invalid.
  - Invalid address: set `err_o` and go to DRAIN.
  - DRAIN consumes 4·N payload bytes without writing, then goes to CMD or CSUM.
- DATA: byte k of a word goes to `data_o[8k+7:8k]`. After byte 3 the state moves to WRITE.
- WRITE: lasts exactly one cycle with `req_o`=`en_o`=1 and `b_en_o`=4'hF.
- WAIT_RSP: waits for `a_rvalid_i`, then increments `addr_o` by 4 and decrements the remaining count.
  - Count not exhausted: go to DATA.
  - Count exhausted: go to CMD or CSUM.
- Mid-block overrun: if the next `addr_o` would reach the end of RAM, set `err_o` and DRAIN the remaining bytes. `addr_o` never wraps.
- Timeout: if `a_rvalid_i` is absent for `RspTimeout` cycles in WAIT_RSP, set `err_o` and DRAIN the remaining words.
- `rx_ready_o`=1 only in CMD, ADDR, LEN, DATA, DRAIN and CSUM.

## Timing
- Last data byte accepted at edge N: `req_o`/`en_o` are high for the cycle after edge N only.
- `addr_o`, `data_o` and `b_en_o` are stable from WRITE until `a_rvalid_i` is sampled.
- `a_rvalid_i` counts only from the cycle after WRITE. A value in the WRITE cycle itself is ignored.
- The earliest next byte is accepted in the cycle after `a_rvalid_i`. Peak throughput is one word per 6 cycles.
- RUN takes effect with `rst_no`=1 on the edge that accepts the opcode.
- `b_en_o` returns to 0 outside WRITE and WAIT_RSP.
- Asserting reset mid-operation returns all outputs to their reset values immediately (asynchronously). Any partial word is lost.

## Configuration
- Macro `RAM_LOAD_CHECKSUM_EN`.
- Defined:
  - After every LOAD payload (including N=0 and drained blocks), one checksum byte is expected: the sum mod 256 of all address, length and payload bytes.
  - A mismatch sets `err_o`.
  - RUN is rejected while `err_o`=1: `rst_no` stays 0.
- Undefined: there is no CSUM state and no checksum byte, and RUN is always honoured.

## Test plan
- Load with address 0x0010_0000, N=2, words 0x11223344 and 0x55667788, RAM responding 1 cycle after req:
  - Two writes, at 0x0010_0000 and 0x0010_0004, with `data_o` 0x11223344 then 0x55667788 and `b_en_o`=F.
  - RUN then drives `rst_no`=1.
- Address 0x0010_0002 with N=1: no `req_o` pulse, 4 bytes consumed, `err_o`=1; a following LOAD clears it.
- Address `BaseAddr+4*(RamWords-1)` with N=2: one write, then `err_o`=1 and 4 bytes drained.
- `a_rvalid_i` held low: `err_o` after 255 cycles in WAIT_RSP, and remaining bytes drained.
- Opcode 0x7F: `err_o`=1, state CMD. Reset asserted mid-DATA: all outputs reset, `rst_no`=0.
- With `RAM_LOAD_CHECKSUM_EN`, send a wrong checksum byte: `err_o`=1 and a subsequent RUN leaves `rst_no`=0. A correct checksum followed by RUN gives `rst_no`=1.
